// File: rtl/window_fetch_ram.sv
// Frame-buffer RAM with a sequential WIN x WIN neighbourhood fetch engine.
// Optional macro WINDOW_ZERO_PAD_EN: out-of-image taps read as zero instead of edge-replicated.
`timescale 1ns/1ps
module window_fetch_ram #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int WIN    = 3,
    parameter int X_W    = $clog2(IMG_W),
    parameter int Y_W    = $clog2(IMG_H),
    parameter int ADDR_W = $clog2(IMG_W*IMG_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [X_W-1:0]             req_x,
    input  logic [Y_W-1:0]             req_y,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [WIN*WIN*DATA_W-1:0]  win_data,
    output logic                       busy
);

    localparam int R    = (WIN-1)/2;
    localparam int NTAP = WIN*WIN;
    localparam int NPIX = IMG_W*IMG_H;
    localparam int K_W  = $clog2(NTAP+1);
    localparam int SX_W = X_W + $clog2(WIN) + 2;
    localparam int SY_W = Y_W + $clog2(WIN) + 2;

    localparam logic [X_W-1:0]         X_MAX  = X_W'(IMG_W-1);
    localparam logic [Y_W-1:0]         Y_MAX  = Y_W'(IMG_H-1);
    localparam logic signed [SX_W-1:0] SX_MAX = SX_W'(IMG_W-1);
    localparam logic signed [SY_W-1:0] SY_MAX = SY_W'(IMG_H-1);
    localparam logic signed [SX_W-1:0] SX_R   = SX_W'(R);
    localparam logic signed [SY_W-1:0] SY_R   = SY_W'(R);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;

    state_t                     state_q, state_d;
    logic [K_W-1:0]             k_q, k_d;
    logic [K_W-1:0]             col_q, col_d;
    logic [K_W-1:0]             row_q, row_d;
    logic [X_W-1:0]             cx_q, cx_d;
    logic [Y_W-1:0]             cy_q, cy_d;
    logic                       win_valid_q, win_valid_d;
    logic [NTAP*DATA_W-1:0]     win_data_q, win_data_d;

    logic [DATA_W-1:0]          mem [NPIX];
    logic [DATA_W-1:0]          rd_q;
    logic [ADDR_W-1:0]          rd_addr;
    logic signed [SX_W-1:0]     sx;
    logic signed [SY_W-1:0]     sy;
    logic [X_W-1:0]             tx;
    logic [Y_W-1:0]             ty;
    logic                       cap_en;
    logic [K_W-1:0]             cap_idx;
    logic [DATA_W-1:0]          cap_val;

`ifdef WINDOW_ZERO_PAD_EN
    logic oob;
    logic pad_q, pad_d;
    logic rd_en;
`endif

    // Tap coordinate = latched centre + (col,row) - R, clamped to the image.
    always_comb begin
        sx = SX_W'(cx_q) + SX_W'(col_q) - SX_R;
        sy = SY_W'(cy_q) + SY_W'(row_q) - SY_R;
        if (sx < 0)            tx = '0;
        else if (sx > SX_MAX)  tx = X_MAX;
        else                   tx = X_W'(sx);
        if (sy < 0)            ty = '0;
        else if (sy > SY_MAX)  ty = Y_MAX;
        else                   ty = Y_W'(sy);
        rd_addr = ADDR_W'(ty) * ADDR_W'(IMG_W) + ADDR_W'(tx);
    end

`ifdef WINDOW_ZERO_PAD_EN
    assign oob   = (sx < 0) || (sx > SX_MAX) || (sy < 0) || (sy > SY_MAX);
    assign rd_en = (state_q == S_FETCH) && !oob;
`endif

    // NOTE: the pixel array has no reset; clearing a RAM would cost a full-array
    // reset network and the contents are always written before being used.
    always_ff @(posedge clk) begin
        if (we && !rst && (32'(wr_addr) < NPIX))
            mem[wr_addr] <= wr_data;
`ifdef WINDOW_ZERO_PAD_EN
        if (rd_en)
            rd_q <= mem[rd_addr];
`else
        rd_q <= mem[rd_addr];
`endif
    end

    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        col_d       = col_q;
        row_d       = row_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        cap_en      = 1'b0;
        cap_idx     = k_q - K_W'(1);
        cap_val     = rd_q;
`ifdef WINDOW_ZERO_PAD_EN
        pad_d = oob;
        if (pad_q)
            cap_val = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    cx_d    = ((X_W+1)'(req_x) > (X_W+1)'(IMG_W-1)) ? X_MAX : req_x;
                    cy_d    = ((Y_W+1)'(req_y) > (Y_W+1)'(IMG_H-1)) ? Y_MAX : req_y;
                    k_d     = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                k_d = k_q + K_W'(1);
                if (col_q == K_W'(WIN-1)) begin
                    col_d = '0;
                    row_d = row_q + K_W'(1);
                end else begin
                    col_d = col_q + K_W'(1);
                end
                // rd_q holds the tap addressed in the previous cycle.
                cap_en = (k_q != '0);
                if (k_q == K_W'(NTAP-1))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                cap_en      = 1'b1;
                cap_idx     = K_W'(NTAP-1);
                win_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (win_ready) begin
                    win_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cap_en)
            win_data_d[cap_idx*DATA_W +: DATA_W] = cap_val;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous and wins over all other updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
`ifdef WINDOW_ZERO_PAD_EN
            pad_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
`ifdef WINDOW_ZERO_PAD_EN
            pad_q       <= pad_d;
`endif
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;

endmodule
